// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter: serialises ICache refills and LSB loads/stores
// into single-byte beats, assembles little-endian read words, honours IO write
// back-pressure, mispredict flushes and the global rdy freeze.
module mem_arbiter #(
  parameter int         IC_BYTES  = 4,
  parameter logic [1:0] IO_SEL_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        IC_req,
  input  logic [31:0] IC_addr,
  output logic        IC_done,
  output logic [31:0] IC_data,
  input  logic        LSB_req,
  input  logic        LSB_wr,
  input  logic [31:0] LSB_addr,
  input  logic [1:0]  LSB_size,
  input  logic [31:0] LSB_wdata,
  output logic        LSB_done,
  output logic [31:0] LSB_rdata,
  input  logic        ROB_jp_wrong
);

  typedef enum logic [1:0] {IDLE, IC_RD, LS_RD, LS_WR} state_t;

  localparam logic [2:0] IC_N = 3'(IC_BYTES);

  // Beat count for an LSB access; the illegal size code behaves as a word.
  function automatic logic [2:0] size_beats(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [2:0]  n_q, n_nx;
  logic        io_q, io_nx;
  logic [31:0] mem_a_q, mem_a_nx;
  logic [7:0]  mem_dout_nx;
  logic [31:0] ic_data_nx, lsb_rdata_nx;
  logic        ic_done_q, ic_done_nx;
  logic        lsb_done_q, lsb_done_nx;
  logic        lsb_done_rd, lsb_done_rd_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic [31:0] buf_q, buf_nx;
  logic [2:0]  cnt_p1, cnt_m1;
  logic        stall;
  logic        rd_state;
  logic        rewind;

  assign cnt_p1   = cnt + 3'd1;
  assign cnt_m1   = cnt - 3'd1;
  assign stall    = io_q & io_buffer_full;
  assign rd_state = (state == IC_RD) || (state == LS_RD);

  // While frozen mid-read, the byte still owed by the RAM belongs to the
  // previous beat; re-presenting that address keeps it on mem_din so the
  // capture on the first enabled cycle sees the same byte as without a freeze.
  assign rewind = !rdy && rd_state && (cnt != 3'd0) && (cnt != n_q);
  assign mem_a  = rewind ? (mem_a_q - 32'd1) : mem_a_q;

  assign mem_wr   = rdy && (state == LS_WR) && !stall;
  // A flush in the done cycle cancels read completions; store completions stand.
  assign IC_done  = ic_done_q & ~ROB_jp_wrong;
  assign LSB_done = lsb_done_q & ~(ROB_jp_wrong & lsb_done_rd);

  // Next-state, beat sequencing and read-byte assembly.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    n_nx           = n_q;
    io_nx          = io_q;
    mem_a_nx       = mem_a_q;
    mem_dout_nx    = mem_dout;
    ic_data_nx     = IC_data;
    lsb_rdata_nx   = LSB_rdata;
    ic_done_nx     = 1'b0;
    lsb_done_nx    = 1'b0;
    lsb_done_rd_nx = lsb_done_rd;
    wdata_nx       = wdata_q;
    buf_nx         = buf_q;
    case (state)
      IDLE: begin
        // The done cycle is never a grant cycle, so a requester cannot be
        // re-granted on the req it is about to drop.
        if (!ic_done_q && !lsb_done_q) begin
          if (LSB_req && (LSB_wr || !ROB_jp_wrong)) begin
            state_nx    = LSB_wr ? LS_WR : LS_RD;
            cnt_nx      = 3'd0;
            n_nx        = size_beats(LSB_size);
            io_nx       = (LSB_addr[17:16] == IO_SEL_HI);
            mem_a_nx    = LSB_addr;
            mem_dout_nx = LSB_wdata[7:0];
            wdata_nx    = LSB_wdata;
            buf_nx      = '0;
          end else if (IC_req && !ROB_jp_wrong) begin
            state_nx = IC_RD;
            cnt_nx   = 3'd0;
            n_nx     = IC_N;
            io_nx    = 1'b0;
            mem_a_nx = IC_addr;
            buf_nx   = '0;
          end
        end
      end
      IC_RD, LS_RD: begin
        if (ROB_jp_wrong) begin
          state_nx = IDLE;
        end else begin
          if (cnt != 3'd0)
            buf_nx[{cnt_m1[1:0], 3'b000} +: 8] = mem_din;
          if (cnt == n_q) begin
            state_nx = IDLE;
            if (state == IC_RD) begin
              ic_data_nx = buf_nx;
              ic_done_nx = 1'b1;
            end else begin
              lsb_rdata_nx   = buf_nx;
              lsb_done_nx    = 1'b1;
              lsb_done_rd_nx = 1'b1;
            end
          end else begin
            cnt_nx = cnt_p1;
            if (cnt_p1 < n_q)
              mem_a_nx = mem_a_q + 32'd1;
          end
        end
      end
      LS_WR: begin
        if (!stall) begin
          if (cnt_p1 == n_q) begin
            state_nx       = IDLE;
            lsb_done_nx    = 1'b1;
            lsb_done_rd_nx = 1'b0;
          end else begin
            cnt_nx      = cnt_p1;
            mem_a_nx    = mem_a_q + 32'd1;
            mem_dout_nx = wdata_q[{cnt_p1[1:0], 3'b000} +: 8];
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control and visible outputs: async reset, frozen while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      n_q         <= 3'd0;
      io_q        <= 1'b0;
      mem_a_q     <= '0;
      mem_dout    <= '0;
      IC_data     <= '0;
      LSB_rdata   <= '0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      lsb_done_rd <= 1'b0;
    end else if (rdy) begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      n_q         <= n_nx;
      io_q        <= io_nx;
      mem_a_q     <= mem_a_nx;
      mem_dout    <= mem_dout_nx;
      IC_data     <= ic_data_nx;
      LSB_rdata   <= lsb_rdata_nx;
      ic_done_q   <= ic_done_nx;
      lsb_done_q  <= lsb_done_nx;
      lsb_done_rd <= lsb_done_rd_nx;
    end
  end

  // Internal data holding: store data and the read assembly buffer.
  always_ff @(posedge clk) begin
    if (rdy) begin
      wdata_q <= wdata_nx;
      buf_q   <= buf_nx;
    end
  end

endmodule
